// File: rtl/bus_sequencer_if.sv
// Bus-sequencer signal bundle: SPI handshake plus bus timing strobes.
// master = sequencer side, slave = consumer (spi1 / bus decode).
interface bus_sequencer_if;
    logic       spi_valid_i;
    logic       spi_ready_o;
    logic       spi_en_o;
    logic       cpu_en_o;
    logic       cpu_clk_o;
    logic       cpu_be_o;
    logic       vid_en_o;
    logic       vid_slot_o;
    logic       clk8_o;
    logic [3:0] tick_o;

    modport master (
        input  spi_valid_i,
        output spi_ready_o, spi_en_o, cpu_en_o, cpu_clk_o,
        output cpu_be_o, vid_en_o, vid_slot_o, clk8_o, tick_o
    );

    modport slave (
        output spi_valid_i,
        input  spi_ready_o, spi_en_o, cpu_en_o, cpu_clk_o,
        input  cpu_be_o, vid_en_o, vid_slot_o, clk8_o, tick_o
    );
endinterface

// File: rtl/bus_sequencer.sv
// Bus sequencer: splits each 1 us CPU cycle into eight 125 ns slots
// (video, SPI, turnaround, phi2) and serves one SPI transaction per frame.
module bus_sequencer #(
    parameter bit          VIDEO_EN = 1'b1,
    parameter int unsigned SPI_SLOT = 2
) (
    input  logic               clk_sys_i,
    input  logic               reset_i,
    bus_sequencer_if.master    bus
);

    typedef enum logic [1:0] {
        IDLE,
        PENDING,
        ACTIVE
    } spi_state_e;

    // Last tick of the slot before ours, and last tick of our slot.
    localparam logic [3:0] GRANT_TICK = 4'((2 * SPI_SLOT + 15) % 16);
    localparam logic [3:0] LAST_TICK  = 4'((2 * SPI_SLOT + 1) % 16);

    spi_state_e state_q, state_d;
    logic [3:0] tick_q, tick_d;
    logic       run_q, run_d;
    logic       spi_ready_q, spi_ready_d;
    logic       spi_en_q, spi_en_d;
    logic       cpu_en_q, cpu_en_d;
    logic       cpu_clk_q, cpu_clk_d;
    logic       cpu_be_q, cpu_be_d;
    logic       vid_en_q, vid_en_d;
    logic       vid_slot_q, vid_slot_d;
    logic       clk8_q, clk8_d;

    // Next tick, SPI request FSM and registered slot decode of the next tick.
    // run_q holds tick 0 for the first free cycle so it follows reset cleanly.
    always_comb begin
        run_d       = 1'b1;
        tick_d      = run_q ? tick_q + 4'd1 : 4'd0;
        state_d     = state_q;
        spi_ready_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.spi_valid_i) state_d = PENDING;
            end
            PENDING: begin
                if (tick_q == GRANT_TICK) state_d = ACTIVE;
            end
            ACTIVE: begin
                if (tick_q == LAST_TICK) begin
                    state_d     = IDLE;
                    spi_ready_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        spi_en_d   = (state_d == ACTIVE);
        clk8_d     = tick_d[0];
        vid_en_d   = VIDEO_EN && (tick_d < 4'd4);
        vid_slot_d = VIDEO_EN && (tick_d[3:1] == 3'd1);
        cpu_clk_d  = tick_d[3];
        cpu_en_d   = (tick_d[3:1] == 3'd7);
        cpu_be_d   = (tick_d >= 4'd6) && !spi_en_d;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_sys_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            tick_q      <= 4'd0;
            run_q       <= 1'b0;
            spi_ready_q <= 1'b0;
            spi_en_q    <= 1'b0;
            cpu_en_q    <= 1'b0;
            cpu_clk_q   <= 1'b0;
            cpu_be_q    <= 1'b0;
            vid_en_q    <= 1'b0;
            vid_slot_q  <= 1'b0;
            clk8_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            run_q       <= run_d;
            spi_ready_q <= spi_ready_d;
            spi_en_q    <= spi_en_d;
            cpu_en_q    <= cpu_en_d;
            cpu_clk_q   <= cpu_clk_d;
            cpu_be_q    <= cpu_be_d;
            vid_en_q    <= vid_en_d;
            vid_slot_q  <= vid_slot_d;
            clk8_q      <= clk8_d;
        end
    end

    assign bus.tick_o      = tick_q;
    assign bus.spi_ready_o = spi_ready_q;
    assign bus.spi_en_o    = spi_en_q;
    assign bus.cpu_en_o    = cpu_en_q;
    assign bus.cpu_clk_o   = cpu_clk_q;
    assign bus.cpu_be_o    = cpu_be_q;
    assign bus.vid_en_o    = vid_en_q;
    assign bus.vid_slot_o  = vid_slot_q;
    assign bus.clk8_o      = clk8_q;

endmodule

// File: tb/tb_bus_sequencer.sv
// Bench for bus_sequencer: two instances (default and VIDEO_EN=0/SPI_SLOT=0)
// checked every cycle against a frame-arithmetic reference model.
module tb_bus_sequencer;

    logic       clk = 1'b0;
    logic [1:0] rst = 2'b11;
    logic [1:0] vld = 2'b00;

    always #31 clk = ~clk;

    bus_sequencer_if bus0 ();
    bus_sequencer_if bus1 ();

    assign bus0.spi_valid_i = vld[0];
    assign bus1.spi_valid_i = vld[1];

    bus_sequencer u_dut0 (
        .clk_sys_i (clk),
        .reset_i   (rst[0]),
        .bus       (bus0)
    );

    bus_sequencer #(
        .VIDEO_EN (1'b0),
        .SPI_SLOT (0)
    ) u_dut1 (
        .clk_sys_i (clk),
        .reset_i   (rst[1]),
        .bus       (bus1)
    );

    int nvec = 0;
    int nerr = 0;

    // Reference model: cycle k is the cycle after the k-th rising edge.
    int cyc = 0;
    int rst_edge[2] = '{0, 0};
    bit seen[2]     = '{1'b0, 1'b0};
    bit live[2]     = '{1'b0, 1'b0};
    int g[2]        = '{0, 0};
    int slot[2]     = '{2, 0};
    bit ven[2]      = '{1'b1, 1'b0};

    task automatic chk(input string tag, input logic [3:0] obs,
                       input logic [3:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int mtick(input int d, input int k);
        return (k - rst_edge[d] - 1) % 16;
    endfunction

    function automatic bit busy(input int d, input int k);
        return live[d] && (k < g[d] + 3);
    endfunction

    // Model update: reset drops the transaction; an accepted request is
    // granted at the first slot-(S-1) last tick after it becomes pending.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int d = 0; d < 2; d++) begin
            if (rst[d]) begin
                rst_edge[d] <= cyc + 1;
                seen[d]     <= 1'b1;
                live[d]     <= 1'b0;
            end else if (vld[d] && seen[d] && !busy(d, cyc)) begin
                live[d] <= 1'b1;
                g[d]    <= cyc + 1 +
                           ((2 * slot[d] - 2 - mtick(d, cyc) + 32) % 16);
            end
        end
    end

    task automatic check_dut(input int d, input logic rdy, input logic en,
                             input logic ce, input logic cc, input logic be,
                             input logic ve, input logic vs, input logic c8,
                             input logic [3:0] tk);
        int  k;
        int  t;
        bit  inr;
        bit  e_en;
        bit  e_rdy;
        string p;
        k     = cyc;
        inr   = (k == rst_edge[d]);
        t     = inr ? 0 : mtick(d, k);
        e_en  = !inr && live[d] && (k == g[d] + 1 || k == g[d] + 2);
        e_rdy = !inr && live[d] && (k == g[d] + 3);
        p     = $sformatf("d%0d c%0d", d, k);
        chk({p, " tick"},     tk,           4'(t));
        chk({p, " clk8"},     {3'b0, c8},   {3'b0, !inr && t % 2 == 1});
        chk({p, " vid_en"},   {3'b0, ve},   {3'b0, !inr && ven[d] && t < 4});
        chk({p, " vid_slot"}, {3'b0, vs},
            {3'b0, !inr && ven[d] && (t == 2 || t == 3)});
        chk({p, " cpu_clk"},  {3'b0, cc},   {3'b0, !inr && t >= 8});
        chk({p, " cpu_en"},   {3'b0, ce},   {3'b0, !inr && t >= 14});
        chk({p, " cpu_be"},   {3'b0, be},   {3'b0, !inr && t >= 6});
        chk({p, " spi_en"},   {3'b0, en},   {3'b0, e_en});
        chk({p, " spi_ready"}, {3'b0, rdy}, {3'b0, e_rdy});
    endtask

    // Compare every output of both instances mid-cycle.
    always @(negedge clk) begin
        if (seen[0])
            check_dut(0, bus0.spi_ready_o, bus0.spi_en_o, bus0.cpu_en_o,
                      bus0.cpu_clk_o, bus0.cpu_be_o, bus0.vid_en_o,
                      bus0.vid_slot_o, bus0.clk8_o, bus0.tick_o);
        if (seen[1])
            check_dut(1, bus1.spi_ready_o, bus1.spi_en_o, bus1.cpu_en_o,
                      bus1.cpu_clk_o, bus1.cpu_be_o, bus1.vid_en_o,
                      bus1.vid_slot_o, bus1.clk8_o, bus1.tick_o);
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_tick(input int d, input int t);
        int n;
        n = 0;
        do begin
            step(1);
            n++;
        end while (mtick(d, cyc) != t && n < 40);
        if (mtick(d, cyc) != t)
            chk($sformatf("d%0d wait_tick %0d timeout", d, t),
                4'(mtick(d, cyc)), 4'(t));
    endtask

    task automatic pulse(input int d);
        vld[d] = 1'b1;
        step(1);
        vld[d] = 1'b0;
    endtask

    initial begin
        logic [1:0] pr;
        step(3);
        rst = 2'b00;
        step(64);

        for (int d = 0; d < 2; d++) begin
            wait_tick(d, 0);
            pulse(d);
            step(20);
            wait_tick(d, 2 * slot[d] - 1 < 0 ? 15 : 2 * slot[d] - 1);
            pulse(d);
            step(40);
            wait_tick(d, 0);
            pulse(d);
            wait_tick(d, 2 * slot[d] + 2);
            pulse(d);
            wait_tick(d, 10);
            pulse(d);
            step(40);
            wait_tick(d, 14);
            pulse(d);
            wait_tick(d, 2 * slot[d]);
            rst[d] = 1'b1;
            step(1);
            rst[d] = 1'b0;
            step(20);
        end

        pr = 2'b00;
        for (int i = 0; i < 3000; i++) begin
            for (int d = 0; d < 2; d++) begin
                rst[d] = ($urandom_range(0, 149) == 0);
                vld[d] = !rst[d] && !pr[d] && ($urandom_range(0, 6) == 0);
            end
            pr = rst;
            step(1);
        end
        rst = 2'b00;
        vld = 2'b00;
        step(40);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/bus_sequencer.md
Name: bus_sequencer

Overview:
- Generates all bus timing from the 16 MHz system clock.
- Divides each 1 µs CPU cycle into eight 125 ns bus slots: video fetch, SPI access, turnaround, and a 65C02 phi2 window.
- Sits directly upstream of the top-level bus decode, feeding it clk8, spi/cpu/video enables, CPU clock and bus-enable.
- Accepts SPI transaction requests from spi1 and returns a completion pulse.

Parameters:
- VIDEO_EN, 1, when 0 the video slots are idle: vid_en_o is held 0 and vid_slot_o is held 0.
- SPI_SLOT, 2, the bus slot (0..3) granted to SPI; 0 and 1 are legal only when VIDEO_EN=0.

Ports:
- clk_sys_i  input  1  16 MHz system clock; all logic on rising edge.
- reset_i  input  1  synchronous, active-high reset.
- spi_valid_i  input  1  one-cycle request pulse from spi1; spi_addr/data/rw_n are stable until spi_ready_o.
- spi_ready_o  output  1  one-cycle completion pulse; read data was captured this frame.
- spi_en_o  output  1  FPGA owns the bus for the SPI transaction.
- cpu_en_o  output  1  CPU data phase (last 125 ns of phi2).
- cpu_clk_o  output  1  65C02 PHI2, 1 MHz, 50% duty.
- cpu_be_o  output  1  65C02 bus enable.
- vid_en_o  output  1  video fetch slot active.
- vid_slot_o  output  1  0 = character fetch, 1 = pattern fetch.
- clk8_o  output  1  8 MHz bus strobe; high in the second half of each slot.
- tick_o  output  4  current tick number, for debug and verification.

Behaviour:
- Tick counter: 4 bits, increments every clk_sys_i and wraps 15 -> 0.
  - A frame is ticks 0..15.
  - Slot s covers ticks 2s and 2s+1.
- All outputs are registered: "during tick n" means the cycle in which tick_o == n.
- Reset values (cycle after reset_i sampled high):
  - tick counter = 0.
  - All outputs = 0.
  - Pending request cleared.
  - The first post-reset cycle is tick 0.
- clk8_o: 0 on even ticks, 1 on odd ticks.
- Video (VIDEO_EN=1):
  - vid_en_o = 1 during ticks 0..3.
  - vid_slot_o = 0 during ticks 0..1, 1 during ticks 2..3.
- CPU:
  - cpu_clk_o = 1 during ticks 8..15, 0 during ticks 0..7.
  - cpu_en_o = 1 during ticks 14..15 only.
  - cpu_be_o = 0 during ticks 0..5, 1 during ticks 6..15. Slot 3 gives address setup before phi2.
- SPI request FSM, states IDLE, PENDING, ACTIVE:
  - IDLE: spi_valid_i=1 -> PENDING.
  - PENDING: on the cycle where tick == 2*SPI_SLOT-1 (mod 16), go to ACTIVE. spi_en_o is 1 during ticks 2*SPI_SLOT and 2*SPI_SLOT+1.
  - ACTIVE: after the second SPI tick go to IDLE. spi_ready_o = 1 for exactly one cycle, during tick 2*SPI_SLOT+2.
  - Grant sampling: a request must be in PENDING by the end of tick 2*SPI_SLOT-1 to be served that frame. A valid pulse arriving during that tick is served the next frame. Worst-case latency is valid -> ready in 19 cycles.
  - spi_valid_i while PENDING or ACTIVE is ignored (protocol violation); no second transaction results.
  - Valid arriving in the same cycle as spi_ready_o is accepted: IDLE -> PENDING.
  - At most one SPI transaction per frame. Throughput is 1 transaction/µs.
- Exclusivity invariants: spi_en_o, vid_en_o and cpu_en_o are never simultaneously 1. cpu_be_o = 0 whenever spi_en_o or vid_en_o = 1.
- Reset mid-operation:
  - Any PENDING or ACTIVE request is dropped with no spi_ready_o pulse. spi1 is reset by the same reset_i.
  - spi_en_o falls the cycle after reset_i is sampled.

Test Plan:
- Reset held 3 cycles, then released -> all outputs 0 during reset; first free cycle tick_o=0, vid_en_o=1, cpu_clk_o=0, cpu_be_o=0.
- Free-run 64 cycles, no SPI -> clk8_o toggles every cycle; cpu_clk_o period 16 cycles, high for ticks 8..15; cpu_en_o high only at ticks 14,15; cpu_be_o low only at ticks 0..5; vid_slot_o=1 only at ticks 2,3.
- spi_valid_i pulse at tick 0 -> spi_en_o high at ticks 4,5 of the same frame; spi_ready_o at tick 6; exactly one pulse.
- spi_valid_i pulse at tick 3 -> no spi_en_o this frame; spi_en_o at ticks 4,5 of the next frame (tick_o sequence 4,5); spi_ready_o 19 cycles after valid.
- spi_valid_i re-pulsed the cycle spi_ready_o fires, plus a spurious pulse while PENDING -> exactly one further transaction, next frame; total two ready pulses.
- reset_i asserted at tick 4 with a request ACTIVE -> spi_en_o 0 next cycle, no spi_ready_o. With VIDEO_EN=0, SPI_SLOT=0: spi_en_o at ticks 0,1 and vid_en_o always 0.
